hvac_zone_ctrl: RTL and testbench

Parametrised multi-zone successor to the single-zone air-conditioning controller. Runs one heat/cool hysteresis state machine per zone over a packed temperature bus. Adds an operating-mode input, a minimum-dwell timer per zone for plant protection, and per-zone sensor-fault detection. Sits between the zone temperature sensors and the heater/cooler drive stage.

---
 rtl/hvac_zone_ctrl.sv | 102 ++++++++++
 tb/tb_hvac_zone_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hvac_zone_ctrl.sv
// rtl/hvac_zone_ctrl.sv - per-zone heat/cool hysteresis controller with dwell timer and sensor-fault detection
// Each zone runs its own IDLE/HEAT/COOL machine; only mode and reset are shared.
module hvac_zone_ctrl #(
  parameter int TEMP_W    = 5,
  parameter int ZONES     = 4,
  parameter int HEAT_ON   = 18,
  parameter int HEAT_OFF  = 20,
  parameter int COOL_ON   = 22,
  parameter int COOL_OFF  = 20,
  parameter int MIN_DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic [ZONES*TEMP_W-1:0] temperature,
  output logic [ZONES-1:0]        heating,
  output logic [ZONES-1:0]        cooling,
  output logic [ZONES-1:0]        fault
);

  localparam int DW_MAX = (MIN_DWELL < 1) ? 1 : MIN_DWELL;
  localparam int CNT_W  = $clog2(DW_MAX + 1);

  localparam logic [TEMP_W-1:0] HEAT_ON_T  = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] HEAT_OFF_T = TEMP_W'(HEAT_OFF);
  localparam logic [TEMP_W-1:0] COOL_ON_T  = TEMP_W'(COOL_ON);
  localparam logic [TEMP_W-1:0] COOL_OFF_T = TEMP_W'(COOL_OFF);
  localparam logic [TEMP_W-1:0] SENSOR_BAD = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(DW_MAX);
  localparam logic [CNT_W-1:0]  CNT_RST    = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  if (!(HEAT_ON < HEAT_OFF && HEAT_OFF <= COOL_OFF && COOL_OFF < COOL_ON &&
        COOL_ON < (1 << TEMP_W) - 1)) begin : g_bad_params
    $fatal(1, "hvac_zone_ctrl: illegal threshold parameters");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, HEAT = 2'd1, COOL = 2'd2} state_e;

  for (genvar z = 0; z < ZONES; z++) begin : g_zone
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fault_q, fault_d;
    logic [TEMP_W-1:0]  temp;
    logic               sensor_bad;
    logic               forced;
    logic               dwell_ok;

    assign temp       = temperature[z*TEMP_W +: TEMP_W];
    assign sensor_bad = (temp == SENSOR_BAD);

    // With MIN_DWELL of 0 or 1 every cycle already satisfies the dwell.
    if (MIN_DWELL <= 1) begin : g_no_dwell
      assign dwell_ok = 1'b1;
    end else begin : g_dwell
      assign dwell_ok = (cnt_q >= CNT_RST);
    end

    always_comb begin
      state_d = state_q;
      fault_d = 1'b0;
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      forced  = sensor_bad || (mode == 2'b00) ||
                (mode == 2'b01 && state_q == COOL) ||
                (mode == 2'b10 && state_q == HEAT);

      if (forced) begin
        state_d = IDLE;
        fault_d = sensor_bad;
        cnt_d   = CNT_ONE;
      end else if (dwell_ok) begin
        unique case (state_q)
          IDLE: begin
            if (temp <= HEAT_ON_T && mode[0])      state_d = HEAT;
            else if (temp >= COOL_ON_T && mode[1]) state_d = COOL;
          end
          HEAT:    if (temp >= HEAT_OFF_T) state_d = IDLE;
          COOL:    if (temp <= COOL_OFF_T) state_d = IDLE;
          default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = CNT_ONE;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= CNT_RST;
        fault_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        fault_q <= fault_d;
      end
    end

    assign heating[z] = (state_q == HEAT);
    assign cooling[z] = (state_q == COOL);
    assign fault[z]   = fault_q;
  end

endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// tb/tb_hvac_zone_ctrl.sv - scoreboard bench for hvac_zone_ctrl at MIN_DWELL=4 and MIN_DWELL=0
// Driver pushes model expectations per edge; monitor pops and compares after each edge.
module tb_hvac_zone_ctrl;

  localparam int T_HEAT_ON  = 18;
  localparam int T_HEAT_OFF = 20;
  localparam int T_COOL_ON  = 22;
  localparam int T_COOL_OFF = 20;
  localparam int S_IDLE = 0, S_HEAT = 1, S_COOL = 2;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic [19:0] temperature;
  logic [3:0]  heat4, cool4, flt4;
  logic [3:0]  heat0, cool0, flt0;

  typedef struct packed {
    logic [3:0] h4, c4, f4, h0, c0, f0;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  int m_st[2][4];
  int m_since[2][4];
  bit m_flt[2][4];
  int cur[4];

  hvac_zone_ctrl #(.MIN_DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .temperature(temperature),
    .heating(heat4), .cooling(cool4), .fault(flt4)
  );

  hvac_zone_ctrl #(.MIN_DWELL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .temperature(temperature),
    .heating(heat0), .cooling(cool0), .fault(flt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: dwell tracked as "cycles since last entry/forced edge", unbounded.
  task automatic step(input bit r, input int m, input int t0, input int t1, input int t2, input int t3);
    int   t[4];
    int   dw, nxt;
    bit   bad, forced;
    exp_t e;
    t = '{t0, t1, t2, t3};
    @(negedge clk);
    rst_n = r;
    mode  = 2'(m);
    for (int z = 0; z < 4; z++) temperature[z*5 +: 5] = 5'(t[z]);
    e = '0;
    for (int p = 0; p < 2; p++) begin
      dw = (p == 0) ? 4 : 0;
      for (int z = 0; z < 4; z++) begin
        if (!r) begin
          m_st[p][z] = S_IDLE; m_since[p][z] = 1000; m_flt[p][z] = 1'b0;
        end else begin
          bad    = (t[z] == 31);
          forced = bad || m == 0 || (m == 1 && m_st[p][z] == S_COOL) || (m == 2 && m_st[p][z] == S_HEAT);
          if (forced) begin
            m_st[p][z] = S_IDLE; m_since[p][z] = 1; m_flt[p][z] = bad;
          end else begin
            m_flt[p][z] = 1'b0;
            nxt = m_st[p][z];
            if (m_since[p][z] >= dw) begin
              if (m_st[p][z] == S_IDLE && t[z] <= T_HEAT_ON && (m == 1 || m == 3)) nxt = S_HEAT;
              else if (m_st[p][z] == S_IDLE && t[z] >= T_COOL_ON && (m == 2 || m == 3)) nxt = S_COOL;
              else if (m_st[p][z] == S_HEAT && t[z] >= T_HEAT_OFF) nxt = S_IDLE;
              else if (m_st[p][z] == S_COOL && t[z] <= T_COOL_OFF) nxt = S_IDLE;
            end
            if (nxt != m_st[p][z]) m_since[p][z] = 1;
            else if (m_since[p][z] < 1000) m_since[p][z]++;
            m_st[p][z] = nxt;
          end
        end
        if (p == 0) begin
          e.h4[z] = (m_st[p][z] == S_HEAT); e.c4[z] = (m_st[p][z] == S_COOL); e.f4[z] = m_flt[p][z];
        end else begin
          e.h0[z] = (m_st[p][z] == S_HEAT); e.c0[z] = (m_st[p][z] == S_COOL); e.f0[z] = m_flt[p][z];
        end
      end
    end
    sbq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("heating_dw4", heat4, e.h4);
        chk("cooling_dw4", cool4, e.c4);
        chk("fault_dw4",   flt4,  e.f4);
        chk("heating_dw0", heat0, e.h0);
        chk("cooling_dw0", cool0, e.c0);
        chk("fault_dw0",   flt0,  e.f0);
        chk("excl_dw4", heat4 & cool4, 4'b0000);
        chk("excl_dw0", heat0 & cool0, 4'b0000);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : driver
    int ramp[7];
    rst_n = 1'b0;
    mode = 2'b11;
    temperature = {4{5'd10}};

    repeat (3) step(0, 3, 10, 10, 10, 10);
    step(1, 3, 10, 10, 10, 10);
    step(1, 3, 10, 10, 10, 10);

    step(0, 3, 20, 20, 20, 20);
    ramp = '{17, 19, 20, 21, 22, 21, 20};
    foreach (ramp[i]) step(1, 3, ramp[i], 20, 20, 20);
    for (int v = 5; v <= 30; v++) step(1, 3, v, 20, 20, 20);
    for (int v = 30; v >= 5; v--) step(1, 3, v, 20, 20, 20);

    step(0, 3, 20, 20, 20, 20);
    step(1, 3, 18, 20, 20, 20);
    repeat (10) step(1, 3, 25, 20, 20, 20);

    repeat (3) step(1, 3, 20, 15, 20, 20);
    step(1, 2, 20, 15, 20, 20);
    repeat (5) step(1, 2, 20, 18, 20, 20);
    repeat (2) step(1, 0, 10, 10, 25, 25);

    step(0, 3, 20, 20, 25, 20);
    repeat (3) step(1, 3, 20, 20, 25, 20);
    step(1, 3, 20, 20, 31, 20);
    repeat (6) step(1, 3, 20, 20, 25, 20);

    step(0, 3, 20, 20, 20, 20);
    step(1, 3, 10, 20, 25, 31);
    step(1, 3, 10, 20, 25, 31);

    cur = '{20, 20, 20, 20};
    mode = 2'b11;
    for (int n = 0; n < 3000; n++) begin
      int m;
      m = int'(mode);
      if ($urandom_range(15) == 0) m = int'($urandom_range(3));
      if (m == 0 && $urandom_range(3) != 0) m = 3;
      for (int z = 0; z < 4; z++) begin
        if ($urandom_range(2) == 0) begin
          if ($urandom_range(19) == 0)     cur[z] = 31;
          else if ($urandom_range(1) == 0) cur[z] = int'($urandom_range(26, 14));
          else                             cur[z] = int'($urandom_range(30));
        end
      end
      step(($urandom_range(63) != 0), m, cur[0], cur[1], cur[2], cur[3]);
    end

    @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
